lane_gather: RTL and testbench

LANE_GATHER -- requirements
Module: lane_gather

---
 rtl/lane_gather.sv | 149 ++++++++++++++
 tb/tb_lane_gather.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lane_gather.sv
// Gathers NUM_INPUTS consecutive valid samples, framed by sof_in, into one packed lane vector.
// It tracks framing with a HUNT/FILL machine and counts framing errors in a saturating counter.
module lane_gather #(
  parameter int NUM_INPUTS      = 10,
  parameter int INPUT_WIDTH     = 16,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          valid_in,
  input  logic                                          sof_in,
  input  logic signed [INPUT_WIDTH-1:0]                 data_in,
  output logic                                          valid_out,
  output logic signed [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] data_out,
  output logic                                          aligned,
  output logic [ERR_COUNT_WIDTH-1:0]                    misalign_count
);

  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_INPUTS - 1);

  generate
    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("lane_gather: NUM_INPUTS must be at least 2");
    end
  endgenerate

  typedef enum logic {
    HUNT = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                                   r_state;
  logic [CNT_W-1:0]                         r_cnt;
  // The last lane is never stored: it goes straight from data_in into data_out.
  logic [NUM_INPUTS-2:0][INPUT_WIDTH-1:0]   r_lanes;
  logic                                     r_valid_out;
  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]   r_data_out;
  logic                                     r_aligned;
  logic [ERR_COUNT_WIDTH-1:0]               r_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_lane_idx;
  logic             w_lane_we;
  logic             w_emit;
  logic             w_err_inc;

  // Next-state, lane-write, emit and error decisions for the framing machine.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lane_idx  = r_cnt;
    w_lane_we   = 1'b0;
    w_emit      = 1'b0;
    w_err_inc   = 1'b0;
    if (valid_in) begin
      case (r_state)
        HUNT: begin
          if (sof_in) begin
            w_lane_we   = 1'b1;
            w_lane_idx  = '0;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = FILL;
          end else begin
            w_state_nxt = HUNT;
          end
        end
        FILL: begin
          if (sof_in) begin
            // An sof with a partial vector in flight restarts the frame and counts as an error.
            if (r_cnt != '0) begin
              w_err_inc = 1'b1;
            end else begin
              w_err_inc = 1'b0;
            end
            w_lane_we  = 1'b1;
            w_lane_idx = '0;
            w_cnt_nxt  = CNT_W'(1);
          end else if (r_cnt == '0) begin
            w_err_inc   = 1'b1;
            w_state_nxt = HUNT;
          end else if (r_cnt == LAST_LANE) begin
            w_emit    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_lane_we = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_cnt_nxt   = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, lane counter, alignment flag and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= HUNT;
      r_cnt     <= '0;
      r_aligned <= 1'b0;
      r_err     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_aligned <= (w_state_nxt == FILL);
      if (w_err_inc && (r_err != {ERR_COUNT_WIDTH{1'b1}})) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  // Working lane buffer for the vector being assembled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lanes <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS - 1; i++) begin
        if (w_lane_we && (w_lane_idx == CNT_W'(i))) begin
          r_lanes[i] <= data_in;
        end
      end
    end
  end

  // Output vector register: only ever loaded with a complete vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_valid_out <= w_emit;
      if (w_emit) begin
        r_data_out <= {data_in, r_lanes};
      end
    end
  end

  assign valid_out      = r_valid_out;
  assign data_out       = r_data_out;
  assign aligned        = r_aligned;
  assign misalign_count = r_err;

endmodule

// File: tb/tb_lane_gather.sv
// Directed bench for lane_gather with 4 lanes of 16 bits and an 8-bit error counter.
// It checks framing, error handling, reset, randomly gapped frames and counter saturation.
module tb_lane_gather;

  localparam int N = 4;
  localparam int W = 16;
  localparam int E = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        valid_in;
  logic                        sof_in;
  logic signed [W-1:0]         data_in;
  logic                        valid_out;
  logic signed [N-1:0][W-1:0]  data_out;
  logic                        aligned;
  logic [E-1:0]                misalign_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_dout;
  logic [63:0] sb_q[$];

  lane_gather #(.NUM_INPUTS(N), .INPUT_WIDTH(W), .ERR_COUNT_WIDTH(E)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sof_in(sof_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .aligned(aligned),
    .misalign_count(misalign_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] vec4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // One clock with the given inputs; valid_out and the held data_out are checked every cycle.
  task automatic step(input logic v, input logic s, input int d, input logic evo);
    valid_in = v;
    sof_in   = s;
    data_in  = d[15:0];
    @(posedge clk);
    #1;
    check_val("valid_out", {63'd0, valid_out}, {63'd0, evo});
    check_val("data_out", data_out, exp_dout);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    valid_in = 1'b1;
    sof_in   = 1'b1;
    data_in  = 16'h7777;
    exp_dout = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid_out", {63'd0, valid_out}, 64'd0);
    check_val("rst_data_out", data_out, 64'd0);
    check_val("rst_aligned", {63'd0, aligned}, 64'd0);
    check_val("rst_misalign", {56'd0, misalign_count}, 64'd0);
    rst      = 1'b1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
  endtask

  // Frame of four samples with no gap; the pulse lands on the step of the last sample.
  task automatic frame4(input int a, input int b, input int c, input int d);
    step(1'b1, 1'b1, a, 1'b0);
    step(1'b1, 1'b0, b, 1'b0);
    step(1'b1, 1'b0, c, 1'b0);
    exp_dout = vec4(a, b, c, d);
    step(1'b1, 1'b0, d, 1'b1);
  endtask

  initial begin
    logic [15:0] samp[N];
    logic [63:0] want;
    int          rsum;
    int          dsum;

    rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; data_in = '0; exp_dout = 64'd0;
    @(posedge clk);
    do_reset();

    // Samples before any sof are dropped.
    step(1'b1, 1'b0, -1, 1'b0);
    step(1'b1, 1'b0, -2, 1'b0);
    check_val("pre_sof_misalign", {56'd0, misalign_count}, 64'd0);
    check_val("pre_sof_aligned", {63'd0, aligned}, 64'd0);

    // Plain frame 1,2,3,4.
    step(1'b1, 1'b1, 1, 1'b0);
    check_val("sof_aligned", {63'd0, aligned}, 64'd1);
    step(1'b1, 1'b0, 2, 1'b0);
    step(1'b1, 1'b0, 3, 1'b0);
    exp_dout = vec4(1, 2, 3, 4);
    step(1'b1, 1'b0, 4, 1'b1);
    check_val("frame_aligned", {63'd0, aligned}, 64'd1);
    check_val("frame_misalign", {56'd0, misalign_count}, 64'd0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Missing sof after a complete frame, then a good frame.
    step(1'b1, 1'b0, 99, 1'b0);
    check_val("nosof_misalign", {56'd0, misalign_count}, 64'd1);
    check_val("nosof_aligned", {63'd0, aligned}, 64'd0);
    frame4(5, 6, 7, 8);
    check_val("nosof_after_misalign", {56'd0, misalign_count}, 64'd1);

    // Early sof discards the partial 10,11,12.
    do_reset();
    step(1'b1, 1'b1, 10, 1'b0);
    step(1'b1, 1'b0, 11, 1'b0);
    step(1'b1, 1'b0, 12, 1'b0);
    frame4(20, 21, 22, 23);
    check_val("early_sof_misalign", {56'd0, misalign_count}, 64'd1);

    // Back-to-back frames pulse every N cycles.
    frame4(-100, 200, -300, 400);
    frame4(7, -7, 32767, -32768);
    check_val("b2b_misalign", {56'd0, misalign_count}, 64'd1);

    // Reset mid-frame, then samples without sof are ignored until a full sof frame.
    do_reset();
    step(1'b1, 1'b1, 30, 1'b0);
    step(1'b1, 1'b0, 31, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 32, 1'b0);
    step(1'b1, 1'b0, 33, 1'b0);
    check_val("post_rst_aligned", {63'd0, aligned}, 64'd0);
    check_val("post_rst_misalign", {56'd0, misalign_count}, 64'd0);
    frame4(41, 42, 43, 44);

    // 50 frames with ~30% idle cycles; idle cycles carry junk sof/data that must be ignored.
    do_reset();
    for (int f = 0; f < 50; f++) begin
      rsum = 0;
      for (int i = 0; i < N; i++) begin
        samp[i] = 16'($urandom);
        rsum += int'($signed(samp[i]));
      end
      sb_q.push_back({samp[3], samp[2], samp[1], samp[0]});
      for (int i = 0; i < N; i++) begin
        while ($urandom_range(0, 9) < 3) begin
          step(1'b0, 1'($urandom_range(0, 1)), int'($urandom), 1'b0);
        end
        if (i == N - 1) begin
          want     = sb_q.pop_front();
          exp_dout = want;
          step(1'b1, 1'b0, int'(samp[i]), 1'b1);
          dsum = 0;
          for (int k = 0; k < N; k++) begin
            dsum += int'($signed(data_out[k]));
          end
          check_val("rand_sum", 64'(dsum), 64'(rsum));
        end else begin
          step(1'b1, (i == 0) ? 1'b1 : 1'b0, int'(samp[i]), 1'b0);
        end
      end
    end
    check_val("rand_misalign", {56'd0, misalign_count}, 64'd0);

    // Repeated sof: each after the first is an early-sof error; count must stop at all-ones.
    do_reset();
    step(1'b1, 1'b1, 1, 1'b0);
    for (int k = 1; k <= 258; k++) begin
      step(1'b1, 1'b1, k, 1'b0);
      if (k == 254) check_val("sat_254", {56'd0, misalign_count}, 64'd254);
      if (k == 255) check_val("sat_255", {56'd0, misalign_count}, 64'd255);
    end
    check_val("sat_hold", {56'd0, misalign_count}, 64'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
